// File: rtl/vga_pattern_engine.sv
// Multi-mode VGA test-pattern generator: checkerboard, colour bars, tiled bitmap, gradient,
// with per-frame scroll / palette cycling and a 2-stage pixel pipeline that re-times the syncs.
module vga_pattern_engine #(
    parameter int H_BITS      = 10,
    parameter int V_BITS      = 10,
    parameter int COLOR_BITS  = 2,
    parameter int TILE_LOG2   = 5,
    parameter int BAR_LOG2    = 6,
    parameter int SCROLL_STEP = 1,
    parameter int CYCLE_DIV   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [H_BITS-1:0]     hpos,
    input  logic [V_BITS-1:0]     vpos,
    input  logic                  display_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [1:0]            mode_sel,
    input  logic                  scroll_en,
    input  logic                  cycle_en,
    output logic [6:0]            rom_x,
    output logic [6:0]            rom_y,
    input  logic [2:0]            rom_rgb,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic [7:0]            frame_count
);

    typedef enum logic [1:0] {
        MODE_CHECKER  = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_BITMAP   = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_t;

    // Palette index 0 is remapped to white so every mode shows something at pbase 0.
    function automatic logic [2:0] pal(input logic [2:0] idx);
        return (idx == 3'd0) ? 3'b111 : idx;
    endfunction

    function automatic logic [COLOR_BITS-1:0] fill(input logic bit_v);
        return {COLOR_BITS{bit_v}};
    endfunction

    // Per-frame state
    logic [7:0]        frame_q, frame_d;
    logic [H_BITS-1:0] scroll_q, scroll_d;
    logic [2:0]        pbase_q, pbase_d;
    logic [7:0]        div_q, div_d;
    mode_t             mode_q, mode_d;

    // Pipeline stage 1 and stage 2
    logic [COLOR_BITS-1:0] r1_q, g1_q, b1_q, r1_d, g1_d, b1_d;
    logic                  de1_q, hs1_q, vs1_q;
    logic [COLOR_BITS-1:0] r2_q, g2_q, b2_q;
    logic                  hs2_q, vs2_q;

    logic              tick;
    logic [H_BITS-1:0] sx;
    logic [2:0]        base_c;
    logic [2:0]        bar_c;
    logic [2:0]        bmp_c;
    logic              chk_on;

    assign tick   = (hpos == '0) && (vpos == '0);
    assign sx     = hpos + scroll_q;
    assign rom_x  = sx[6:0];
    assign rom_y  = vpos[6:0];
    assign base_c = pal(pbase_q);
    assign bar_c  = pal(3'(sx >> BAR_LOG2) + pbase_q);
    assign bmp_c  = base_c & rom_rgb;
    assign chk_on = sx[TILE_LOG2] ^ vpos[TILE_LOG2];

    always_comb begin
        frame_d  = frame_q;
        scroll_d = scroll_q;
        pbase_d  = pbase_q;
        div_d    = div_q;
        mode_d   = mode_q;
        if (tick) begin
            frame_d = frame_q + 8'd1;
            mode_d  = mode_t'(mode_sel);
            if (scroll_en) begin
                scroll_d = scroll_q + H_BITS'(SCROLL_STEP);
            end
            if (cycle_en) begin
                if (div_q == 8'(CYCLE_DIV - 1)) begin
                    div_d   = 8'd0;
                    pbase_d = pbase_q + 3'd1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
        end
    end

    // Pattern colour uses the pre-tick mode/scroll/pbase, so pixel (0,0) belongs to the old frame.
    always_comb begin
        r1_d = '0;
        g1_d = '0;
        b1_d = '0;
        case (mode_q)
            MODE_CHECKER: begin
                r1_d = fill(chk_on & base_c[2]);
                g1_d = fill(chk_on & base_c[1]);
                b1_d = fill(chk_on & base_c[0]);
            end
            MODE_BARS: begin
                r1_d = fill(bar_c[2]);
                g1_d = fill(bar_c[1]);
                b1_d = fill(bar_c[0]);
            end
            MODE_BITMAP: begin
                r1_d = fill(bmp_c[2]);
                g1_d = fill(bmp_c[1]);
                b1_d = fill(bmp_c[0]);
            end
            MODE_GRADIENT: begin
                r1_d = sx[H_BITS-1 -: COLOR_BITS];
                g1_d = vpos[V_BITS-1 -: COLOR_BITS];
                b1_d = frame_q[7 -: COLOR_BITS];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q  <= '0;
            scroll_q <= '0;
            pbase_q  <= '0;
            div_q    <= '0;
            mode_q   <= MODE_CHECKER;
            r1_q     <= '0;
            g1_q     <= '0;
            b1_q     <= '0;
            de1_q    <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            r2_q     <= '0;
            g2_q     <= '0;
            b2_q     <= '0;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            scroll_q <= scroll_d;
            pbase_q  <= pbase_d;
            div_q    <= div_d;
            mode_q   <= mode_d;
            r1_q     <= r1_d;
            g1_q     <= g1_d;
            b1_q     <= b1_d;
            de1_q    <= display_on;
            hs1_q    <= hsync_in;
            vs1_q    <= vsync_in;
            r2_q     <= de1_q ? r1_q : '0;
            g2_q     <= de1_q ? g1_q : '0;
            b2_q     <= de1_q ? b1_q : '0;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
        end
    end

    assign r           = r2_q;
    assign g           = g2_q;
    assign b           = b2_q;
    assign hsync_out   = hs2_q;
    assign vsync_out   = vs2_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Bench for vga_pattern_engine: expected pixels queued at drive time, compared 2 cycles later.
module tb_vga_pattern_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       display_on = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [1:0] mode_sel = '0;
    logic       scroll_en = 1'b0;
    logic       cycle_en = 1'b0;
    logic [6:0] rom_x, rom_y;
    logic [2:0] rom_rgb;
    logic [1:0] r, g, b;
    logic       hsync_out, vsync_out;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    vga_pattern_engine dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_sel(mode_sel), .scroll_en(scroll_en),
        .cycle_en(cycle_en), .rom_x(rom_x), .rom_y(rom_y), .rom_rgb(rom_rgb),
        .r(r), .g(g), .b(b), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .frame_count(frame_count)
    );

    // Arbitrary combinational bitmap ROM
    function automatic logic [2:0] rom_fn(input logic [6:0] x, input logic [6:0] y);
        return x[2:0] ^ y[4:2] ^ {y[6], x[6], x[3]};
    endfunction
    assign rom_rgb = rom_fn(rom_x, rom_y);

    typedef struct packed {
        logic [1:0] r, g, b;
        logic       hs, vs;
    } exp_t;

    typedef struct {
        logic [9:0] hp, vp;
        logic       de, hs, vs;
        exp_t       e;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    logic release_req = 1'b0;

    // Reference state, mirrored from the behavioural description
    logic [9:0] m_scroll;
    logic [2:0] m_pbase;
    int         m_div;
    logic [7:0] m_fc;
    logic [1:0] m_mode;

    function automatic logic [2:0] pal(input logic [2:0] i);
        return (i == 3'd0) ? 3'd7 : i;
    endfunction

    function automatic exp_t model_pix(input logic [9:0] hp, input logic [9:0] vp,
                                       input logic de, input logic hs, input logic vs);
        exp_t       e;
        logic [9:0] sx;
        logic [2:0] c;
        logic [2:0] idx;
        sx = hp + m_scroll;
        c = 3'd0;
        e = '0;
        e.hs = hs;
        e.vs = vs;
        case (m_mode)
            2'd0: c = (sx[5] ^ vp[5]) ? pal(m_pbase) : 3'd0;
            2'd1: begin idx = sx[8:6] + m_pbase; c = pal(idx); end
            2'd2: c = pal(m_pbase) & rom_fn(sx[6:0], vp[6:0]);
            default: c = 3'd0;
        endcase
        if (m_mode == 2'd3) begin
            e.r = sx[9:8];
            e.g = vp[9:8];
            e.b = m_fc[7:6];
        end else begin
            e.r = {2{c[2]}};
            e.g = {2{c[1]}};
            e.b = {2{c[0]}};
        end
        if (!de) begin
            e.r = '0; e.g = '0; e.b = '0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_scroll = '0; m_pbase = '0; m_div = 0; m_fc = '0; m_mode = '0;
    endtask

    task automatic drive(input logic [9:0] hp, input logic [9:0] vp, input logic de,
                         input logic hs, input logic vs, input logic [1:0] ms,
                         input logic se, input logic ce, input logic use_tab, input exp_t tab);
        exp_t e;
        @(negedge clk);
        if (q.size() >= 2) begin
            e = q.pop_front();
            chk("rgb", int'({r, g, b}), int'({e.r, e.g, e.b}));
            chk("hsync_out", int'(hsync_out), int'(e.hs));
            chk("vsync_out", int'(vsync_out), int'(e.vs));
        end
        chk("frame_count", int'(frame_count), int'(m_fc));
        if (release_req) begin
            reset = 1'b0;
            release_req = 1'b0;
        end
        hpos = hp; vpos = vp; display_on = de; hsync_in = hs; vsync_in = vs;
        mode_sel = ms; scroll_en = se; cycle_en = ce;
        if (reset) begin
            e = '0;
        end else begin
            e = use_tab ? tab : model_pix(hp, vp, de, hs, vs);
            if (hp == 10'd0 && vp == 10'd0) begin
                m_fc = m_fc + 8'd1;
                m_mode = ms;
                if (se) m_scroll = m_scroll + 10'd1;
                if (ce) begin
                    if (m_div == 7) begin m_div = 0; m_pbase = m_pbase + 3'd1; end
                    else m_div = m_div + 1;
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic pix(input logic [9:0] hp, input logic [9:0] vp, input logic [1:0] ms);
        drive(hp, vp, 1'b1, 1'b0, 1'b0, ms, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic tick(input logic [1:0] ms, input logic se, input logic ce);
        drive(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, ms, se, ce, 1'b0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_blank", int'({r, g, b, hsync_out, vsync_out}), 0);
        q.delete();
        q.push_back('0);
        q.push_back('0);
        model_reset();
    endtask

    vec_t tab[8];

    initial begin
        // Mode 0 at pbase 0 (white), scroll 0
        tab[0] = '{10'd31, 10'd0,  1'b1, 1'b0, 1'b0, '{2'd0, 2'd0, 2'd0, 1'b0, 1'b0}};
        tab[1] = '{10'd32, 10'd0,  1'b1, 1'b0, 1'b0, '{2'd3, 2'd3, 2'd3, 1'b0, 1'b0}};
        tab[2] = '{10'd32, 10'd32, 1'b1, 1'b0, 1'b0, '{2'd0, 2'd0, 2'd0, 1'b0, 1'b0}};
        tab[3] = '{10'd0,  10'd32, 1'b1, 1'b0, 1'b0, '{2'd3, 2'd3, 2'd3, 1'b0, 1'b0}};
        tab[4] = '{10'd63, 10'd0,  1'b1, 1'b0, 1'b1, '{2'd3, 2'd3, 2'd3, 1'b0, 1'b1}};
        tab[5] = '{10'd64, 10'd0,  1'b1, 1'b1, 1'b0, '{2'd0, 2'd0, 2'd0, 1'b1, 1'b0}};
        tab[6] = '{10'd32, 10'd0,  1'b0, 1'b1, 1'b0, '{2'd0, 2'd0, 2'd0, 1'b1, 1'b0}};
        tab[7] = '{10'd96, 10'd64, 1'b1, 1'b0, 1'b0, '{2'd3, 2'd3, 2'd3, 1'b0, 1'b0}};

        // Reset held with random pixels and active syncs: all outputs stay 0
        apply_reset();
        for (int i = 0; i < 4; i++)
            drive(10'($urandom_range(1, 639)), 10'($urandom_range(1, 479)), 1'b1, 1'b1, 1'b1,
                  2'd1, 1'b1, 1'b1, 1'b0, '0);

        // Release mid-frame on a visible white pixel; colour must appear exactly 2 clk later
        release_req = 1'b1;
        pix(10'd40, 10'd10, 2'd0);
        pix(10'd41, 10'd10, 2'd0);
        pix(10'd42, 10'd10, 2'd0);

        for (int i = 0; i < 8; i++)
            drive(tab[i].hp, tab[i].vp, tab[i].de, tab[i].hs, tab[i].vs,
                  2'd0, 1'b0, 1'b0, 1'b1, tab[i].e);

        // mode_sel ignored mid-frame, adopted at (0,0)
        pix(10'd64, 10'd5, 2'd1);
        pix(10'd32, 10'd5, 2'd1);
        tick(2'd1, 1'b0, 1'b0);
        pix(10'd64, 10'd0, 2'd1);

        // Palette cycling: step every 8 ticks, full wrap after 64, frozen when disabled
        for (int i = 0; i < 8; i++) tick(2'd1, 1'b0, 1'b1);
        pix(10'd1, 10'd1, 2'd1);
        for (int i = 0; i < 56; i++) tick(2'd1, 1'b0, 1'b1);
        pix(10'd1, 10'd1, 2'd1);
        for (int i = 0; i < 3; i++) tick(2'd1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick(2'd1, 1'b0, 1'b0);
        pix(10'd130, 10'd1, 2'd1);

        // Scroll: 3 ticks shift the checker edge to hpos 29, then wrap after 1024 ticks
        for (int i = 0; i < 3; i++) tick(2'd0, 1'b1, 1'b0);
        pix(10'd28, 10'd0, 2'd0);
        pix(10'd29, 10'd0, 2'd0);
        for (int i = 0; i < 1021; i++) tick(2'd0, 1'b1, 1'b0);
        pix(10'd31, 10'd0, 2'd0);
        pix(10'd32, 10'd0, 2'd0);

        // Gradient with blanking and a 3-cycle hsync pulse
        tick(2'd3, 1'b0, 1'b0);
        drive(10'd700, 10'd300, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, '0);
        drive(10'd701, 10'd300, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, '0);
        drive(10'd702, 10'd300, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, '0);
        drive(10'd600, 10'd800, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, '0);
        drive(10'd300, 10'd260, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, '0);

        // Random pixels in every mode with scroll/palette state moving between bursts
        for (int m = 0; m < 4; m++) begin
            for (int t = 0; t < 11; t++) tick(2'(m), 1'b1, 1'b1);
            for (int i = 0; i < 30; i++)
                drive(10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      2'(m), 1'b1, 1'b1, 1'b0, '0);
        end

        // Mid-frame reset blanks immediately; restart from clean state
        pix(10'd40, 10'd10, 2'd2);
        apply_reset();
        pix(10'd40, 10'd10, 2'd0);
        release_req = 1'b1;
        pix(10'd40, 10'd10, 2'd0);
        pix(10'd10, 10'd10, 2'd0);

        // Flush the pipeline
        drive(10'd5, 10'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0);
        drive(10'd5, 10'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0);
        drive(10'd5, 10'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
